keccak_round_seq: RTL and testbench

//  Iterative Keccak-p[1600,NUM_ROUNDS] sequencer wrapping the combinational round stage (theta/rho/pi/chi/iota).
//  - Holds the 1600-bit state register and drives it into the round stage as rnd_state_o.
//  - Captures the round result rnd_state_i once per clock and supplies the per-round constant.
//  - Performs one round per cycle and hands the permuted state downstream (sponge absorb/squeeze logic).

---
 rtl/keccak_round_seq_if.sv | 26 ++
 rtl/keccak_round_seq.sv | 143 ++++++++++++++
 tb/tb_keccak_round_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_round_seq_if.sv
// Bus interface for keccak_round_seq. It groups the input stream, the output
// stream, the round-stage link and the permutation counter.
// The sequencer connects through the slave modport. The environment
// (producer, consumer and round stage) connects through the master modport.
interface keccak_round_seq_if;
  logic          in_valid;
  logic          in_ready;
  logic [1599:0] state_in;
  logic          out_valid;
  logic          out_ready;
  logic [1599:0] state_out;
  logic [1599:0] rnd_state_o;
  logic [31:0]   rnd_ir_o;
  logic [1599:0] rnd_state_i;
  logic [31:0]   perm_cnt_o;

  modport slave (
    input  in_valid, state_in, out_ready, rnd_state_i,
    output in_ready, out_valid, state_out, rnd_state_o, rnd_ir_o, perm_cnt_o
  );

  modport master (
    output in_valid, state_in, out_ready, rnd_state_i,
    input  in_ready, out_valid, state_out, rnd_state_o, rnd_ir_o, perm_cnt_o
  );
endinterface

// File: rtl/keccak_round_seq.sv
// Iterative Keccak-p[1600,NUM_ROUNDS] sequencer. It wraps an external
// combinational round stage and runs one round per clock.
// Round indices run from 24-NUM_ROUNDS up to 23.
// The round stage only sees the low 32 bits of each round constant. Bit 63 of
// the constant is folded into lane a00 here, when the round result is captured.
// Optional feature macro: KECCAK_SEQ_PERF_EN. When it is defined, a
// completed-permutation counter drives perm_cnt_o. When it is not defined,
// perm_cnt_o is tied to zero.
module keccak_round_seq #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  keccak_round_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [4:0] FIRST_IDX = 5'(24 - NUM_ROUNDS);
  localparam logic [4:0] LAST_IDX  = 5'd23;

  fsm_t          fsm;
  logic [1599:0] st;
  logic [4:0]    idx;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [32:0]   rc_sel;

  // Keccak round-constant ROM. The result is {RC[63], RC[31:0]}.
  // Bits 32..62 are zero for every constant, so they are not stored.
  function automatic logic [32:0] rc_rom(input logic [4:0] i);
    logic [32:0] r;
    case (i)
      5'd0:    r = {1'b0, 32'h0000_0001};
      5'd1:    r = {1'b0, 32'h0000_8082};
      5'd2:    r = {1'b1, 32'h0000_808A};
      5'd3:    r = {1'b1, 32'h8000_8000};
      5'd4:    r = {1'b0, 32'h0000_808B};
      5'd5:    r = {1'b0, 32'h8000_0001};
      5'd6:    r = {1'b1, 32'h8000_8081};
      5'd7:    r = {1'b1, 32'h0000_8009};
      5'd8:    r = {1'b0, 32'h0000_008A};
      5'd9:    r = {1'b0, 32'h0000_0088};
      5'd10:   r = {1'b0, 32'h8000_8009};
      5'd11:   r = {1'b0, 32'h8000_000A};
      5'd12:   r = {1'b0, 32'h8000_808B};
      5'd13:   r = {1'b1, 32'h0000_008B};
      5'd14:   r = {1'b1, 32'h0000_8089};
      5'd15:   r = {1'b1, 32'h0000_8003};
      5'd16:   r = {1'b1, 32'h0000_8002};
      5'd17:   r = {1'b1, 32'h0000_0080};
      5'd18:   r = {1'b0, 32'h0000_800A};
      5'd19:   r = {1'b1, 32'h8000_000A};
      5'd20:   r = {1'b1, 32'h8000_8081};
      5'd21:   r = {1'b1, 32'h0000_8080};
      5'd22:   r = {1'b0, 32'h8000_0001};
      5'd23:   r = {1'b1, 32'h8000_8008};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Constant lookup for the current round. It is forced to zero outside RUN,
  // so the round stage sees ir=0 while idle or holding a result.
  always_comb begin
    rc_sel = '0;
    if (fsm == RUN) rc_sel = rc_rom(idx);
  end

  assign bus.rnd_ir_o    = rc_sel[31:0];
  assign bus.rnd_state_o = st;
  assign bus.state_out   = st;
  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;

  // Sequencer FSM. It loads a state, iterates the rounds and holds the result.
  // clr takes priority over any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      st          <= '0;
      idx         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (clr) begin
      fsm         <= IDLE;
      idx         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            st         <= bus.state_in;
            idx        <= FIRST_IDX;
            in_ready_r <= 1'b0;
            fsm        <= RUN;
          end
        end
        RUN: begin
          st  <= bus.rnd_state_i ^ {1536'b0, rc_sel[32], 63'b0};
          idx <= idx + 5'd1;
          if (idx == LAST_IDX) begin
            out_valid_r <= 1'b1;
            fsm         <= DONE;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            fsm         <= IDLE;
          end
        end
        default: begin
          fsm         <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef KECCAK_SEQ_PERF_EN
  logic [31:0] perm_cnt;

  // Completed-permutation counter. It is cleared only by rst_n and wraps at
  // 2^32. A handshake suppressed by clr is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_cnt <= '0;
    end else if (!clr && out_valid_r && bus.out_ready) begin
      perm_cnt <= perm_cnt + 32'd1;
    end
  end

  assign bus.perm_cnt_o = perm_cnt;
`else
  assign bus.perm_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_keccak_round_seq.sv
// Testbench for keccak_round_seq. It builds three sequencers with
// NUM_ROUNDS = 24, 12 and 1. Each one is wired to a behavioural Keccak round
// stage on its rnd_* ports.
// The reference permutation derives the rho offsets and the round constants
// from the Keccak definitions (the pi walk and the rc LFSR). It does not use
// lookup tables.
module tb_keccak_round_seq;

  localparam int NI = 3;

  function automatic int nr_of(input int k);
    case (k)
      0:       return 24;
      1:       return 12;
      default: return 1;
    endcase
  endfunction

  logic          clk;
  logic          rst_n;
  logic          clr       [NI];
  logic          in_valid  [NI];
  logic [1599:0] state_in  [NI];
  logic          out_ready [NI];
  logic          in_ready  [NI];
  logic          out_valid [NI];
  logic [1599:0] state_out [NI];
  logic [31:0]   ir        [NI];
  logic [31:0]   pcnt      [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  [NI];

  // ---------------- Keccak reference arithmetic ----------------
  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    int m;
    m = n % 64;
    if (m == 0) return v;
    return (v << m) | (v >> (64 - m));
  endfunction

  function automatic logic rc_bit(input int t);
    logic [7:0] r;
    logic       fb;
    r = 8'h01;
    for (int i = 1; i <= t % 255; i++) begin
      fb = r[7];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h71;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc64(input int rnd);
    logic [63:0] c;
    c = '0;
    for (int j = 0; j < 7; j++) c[(1 << j) - 1] = rc_bit(j + 7 * rnd);
    return c;
  endfunction

  // One Keccak-f round. Lane (x,y) is at index x+5y. rc is XORed into lane 0.
  function automatic logic [1599:0] kround(input logic [1599:0] s, input logic [63:0] rc);
    logic [63:0]   a [25];
    logic [63:0]   b [25];
    logic [63:0]   c [5];
    logic [63:0]   d;
    int            rho [25];
    int            x, y, nx;
    logic [1599:0] r;
    rho[0] = 0;
    x = 1;
    y = 0;
    for (int t = 0; t < 24; t++) begin
      rho[x + 5 * y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      y  = (2 * x + 3 * y) % 5;
      x  = nx;
    end
    for (int i = 0; i < 25; i++) a[i] = s[64 * i +: 64];
    for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i + 5] ^ a[i + 10] ^ a[i + 15] ^ a[i + 20];
    for (int i = 0; i < 25; i++) begin
      d    = c[(i % 5 + 4) % 5] ^ rotl(c[(i % 5 + 1) % 5], 1);
      a[i] = a[i] ^ d;
    end
    for (int i = 0; i < 25; i++) begin
      x = i % 5;
      y = i / 5;
      b[y + 5 * ((2 * x + 3 * y) % 5)] = rotl(a[i], rho[i]);
    end
    for (int i = 0; i < 25; i++) begin
      x    = i % 5;
      y    = i / 5;
      a[i] = b[i] ^ (~b[(x + 1) % 5 + 5 * y] & b[(x + 2) % 5 + 5 * y]);
    end
    a[0] = a[0] ^ rc;
    for (int i = 0; i < 25; i++) r[64 * i +: 64] = a[i];
    return r;
  endfunction

  function automatic logic [1599:0] ref_perm(input logic [1599:0] s, input int nr);
    logic [1599:0] v;
    v = s;
    for (int r = 24 - nr; r < 24; r++) v = kround(v, rc64(r));
    return v;
  endfunction

  function automatic logic [31:0] exp_pcnt(input int k);
`ifdef KECCAK_SEQ_PERF_EN
    return 32'(exp_cnt[k]);
`else
    return 32'(0 * k);
`endif
  endfunction

  // ---------------- DUTs with behavioural round stages ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    keccak_round_seq_if bus ();

    keccak_round_seq #(.NUM_ROUNDS(nr_of(g))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr[g]),
      .bus   (bus)
    );

    assign bus.in_valid    = in_valid[g];
    assign bus.state_in    = state_in[g];
    assign bus.out_ready   = out_ready[g];
    assign bus.rnd_state_i = kround(bus.rnd_state_o, {32'h0, bus.rnd_ir_o});
    assign in_ready[g]     = bus.in_ready;
    assign out_valid[g]    = bus.out_valid;
    assign state_out[g]    = bus.state_out;
    assign ir[g]           = bus.rnd_ir_o;
    assign pcnt[g]         = bus.perm_cnt_o;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic chk_wide(input string nm, input logic [1599:0] got, input logic [1599:0] exp);
    int lane;
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      lane = 0;
      for (int i = 24; i >= 0; i--) if (got[64 * i +: 64] !== exp[64 * i +: 64]) lane = i;
      $display("FAIL %s: lane %0d got %h expected %h", nm, lane, got[64 * lane +: 64], exp[64 * lane +: 64]);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction

  // Waits for in_ready and presents din for exactly one accepting edge.
  task automatic start_perm(input int k, input logic [1599:0] din);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("inst%0d_accept_ready", k), 64'(in_ready[k]), 64'd1);
    in_valid[k] = 1'b1;
    state_in[k] = din;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    state_in[k] = rand_state();
  endtask

  // Counts edges from the accept until out_valid is seen.
  // Along the way it checks rnd_ir_o and in_ready on every RUN cycle.
  task automatic wait_done(input int k, output int lat, output bit ok);
    logic [63:0] rcv;
    int          first;
    first = 24 - nr_of(k);
    lat   = -1;
    ok    = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (out_valid[k]) begin
        lat = c;
        break;
      end
      rcv = rc64(first + c);
      if (ir[k] !== rcv[31:0] || in_ready[k] !== 1'b0) ok = 1'b0;
    end
  endtask

  task automatic handshake(input int k);
    if (out_valid[k]) exp_cnt[k]++;
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("inst%0d_post_hs_in_ready", k), 64'(in_ready[k]), 64'd1);
    chk($sformatf("inst%0d_post_hs_out_valid", k), 64'(out_valid[k]), 64'd0);
  endtask

  task automatic full_perm(input int k, input logic [1599:0] din, input string nm);
    logic [1599:0] exp;
    int            lat;
    bit            ok;
    exp = ref_perm(din, nr_of(k));
    start_perm(k, din);
    wait_done(k, lat, ok);
    chk({nm, "_latency"}, 64'(lat), 64'(nr_of(k)));
    chk({nm, "_ir_trace"}, 64'(ok), 64'd1);
    chk_wide({nm, "_state_out"}, state_out[k], exp);
    chk({nm, "_done_in_ready"}, 64'(in_ready[k]), 64'd0);
    handshake(k);
    chk({nm, "_perm_cnt"}, 64'(pcnt[k]), 64'(exp_pcnt(k)));
  endtask

  task automatic chk_reset_state(input string nm);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_inst%0d_in_ready", nm, k), 64'(in_ready[k]), 64'd1);
      chk($sformatf("%s_inst%0d_out_valid", nm, k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("%s_inst%0d_ir", nm, k), 64'(ir[k]), 64'd0);
      chk($sformatf("%s_inst%0d_perm_cnt", nm, k), 64'(pcnt[k]), 64'd0);
      chk_wide($sformatf("%s_inst%0d_state", nm, k), state_out[k], '0);
    end
  endtask

  typedef struct {
    int            k;
    logic [1599:0] din;
    string         nm;
  } vec_t;

  // ---------------- main sequence ----------------
  initial begin
    vec_t          vecs [$];
    vec_t          v;
    logic [1599:0] d, hold, exp;
    int            lat;
    bit            ok, flag;

    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      clr[k]       = 1'b0;
      in_valid[k]  = 1'b0;
      state_in[k]  = '0;
      out_ready[k] = 1'b0;
      exp_cnt[k]   = 0;
    end

    // Stimulus table: instance, input state and name.
    // Expected results come from ref_perm.
    v.k = 0; v.din = '1;                  v.nm = "v_ones_24";   vecs.push_back(v);
    v.k = 0; v.din = 1600'b1 << 1599;     v.nm = "v_msb_24";    vecs.push_back(v);
    v.k = 0; v.din = rand_state();        v.nm = "v_rand0_24";  vecs.push_back(v);
    v.k = 0; v.din = rand_state();        v.nm = "v_rand1_24";  vecs.push_back(v);
    v.k = 1; v.din = rand_state();        v.nm = "v_rand0_12";  vecs.push_back(v);
    v.k = 1; v.din = '0;                  v.nm = "v_zero_12";   vecs.push_back(v);
    v.k = 2; v.din = rand_state();        v.nm = "v_rand0_1";   vecs.push_back(v);
    v.k = 2; v.din = '0;                  v.nm = "v_zero_1";    vecs.push_back(v);

    // Asynchronous reset, before any clock edge has occurred.
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known answer: the all-zero state through 24 rounds.
    start_perm(0, '0);
    wait_done(0, lat, ok);
    chk("ka_latency", 64'(lat), 64'd24);
    chk("ka_ir_trace", 64'(ok), 64'd1);
    chk("ka_lane00", state_out[0][63:0], 64'hF1258F7940E1DDE7);
    handshake(0);

    // Table-driven vectors.
    foreach (vecs[i]) full_perm(vecs[i].k, vecs[i].din, vecs[i].nm);

    // Backpressure. The result must be held while out_ready is low.
    // in_valid is held high with unrelated data and must be ignored.
    d   = rand_state();
    exp = ref_perm(d, 24);
    start_perm(0, d);
    in_valid[0] = 1'b1;
    state_in[0] = rand_state();
    wait_done(0, lat, ok);
    chk("bp_latency", 64'(lat), 64'd24);
    hold = state_out[0];
    flag = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (state_out[0] !== hold || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) flag = 1'b0;
    end
    chk("bp_hold_stable", 64'(flag), 64'd1);
    chk_wide("bp_state_out", state_out[0], exp);
    in_valid[0] = 1'b0;
    handshake(0);

    // clr while idx is 7: the sequencer aborts and no output appears.
    start_perm(0, rand_state());
    for (int c = 0; c < 8; c++) @(negedge clk);
    chk("clr_at_idx7_ir", 64'(ir[0]), 64'h0000_0000_0000_8009);
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", 64'(in_ready[0]), 64'd1);
    chk("clr_ir_zero", 64'(ir[0]), 64'd0);
    flag = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) flag = 1'b0;
    end
    chk("clr_no_out_valid", 64'(flag), 64'd1);
    full_perm(0, rand_state(), "after_clr");

    // clr takes priority over an input handshake in IDLE.
    @(negedge clk);
    in_valid[1] = 1'b1;
    state_in[1] = rand_state();
    clr[1]      = 1'b1;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    clr[1]      = 1'b0;
    @(negedge clk);
    chk("clr_vs_in_hs_in_ready", 64'(in_ready[1]), 64'd1);
    chk("clr_vs_in_hs_ir", 64'(ir[1]), 64'd0);

    // clr takes priority over an output handshake. No count is taken.
    start_perm(2, rand_state());
    wait_done(2, lat, ok);
    chk("clr_vs_out_hs_latency", 64'(lat), 64'd1);
    out_ready[2] = 1'b1;
    clr[2]       = 1'b1;
    @(posedge clk);
    #1;
    out_ready[2] = 1'b0;
    clr[2]       = 1'b0;
    @(negedge clk);
    chk("clr_vs_out_hs_out_valid", 64'(out_valid[2]), 64'd0);
    chk("clr_vs_out_hs_in_ready", 64'(in_ready[2]), 64'd1);
    chk("clr_vs_out_hs_perm_cnt", 64'(pcnt[2]), 64'(exp_pcnt(2)));

    // Reset pulse in the middle of RUN. Outputs clear without a clock edge.
    start_perm(0, rand_state());
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) exp_cnt[k] = 0;
    chk_reset_state("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) flag = 1'b0;
    end
    chk("midrun_reset_no_stale", 64'(flag), 64'd1);

    // NUM_ROUNDS=12: three permutations, then check the counter.
    for (int i = 0; i < 3; i++) full_perm(1, rand_state(), $sformatf("nr12_run%0d", i));
    chk("nr12_perm_cnt_total", 64'(pcnt[1]), 64'(exp_pcnt(1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
